// File: rtl/alu_mdu_pkg.sv
// Shared definitions for the ALU / multiply-divide unit: funct codes and FSM states.
// Latency: n/a (constants, types and a decode helper only).
// Backpressure: n/a.
package alu_mdu_pkg;

  // MIPS funct codes
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  // Multi-cycle sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2
  } state_t;

  // mult/multu/div/divu all share the 0110xx prefix
  function automatic logic is_mdu_op(input logic [5:0] fn);
    return (fn[5:2] == 4'b0110);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply (shift-add) / restoring divide datapath on magnitudes.
// Latency: WIDTH step cycles after load; zero steps when loaded with skip.
// Backpressure: none; advances only while step is high and the counter is non-zero.
module mdu_iter
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               mode_div,
  input  logic               skip,
  input  logic [WIDTH-1:0]   mag_a,
  input  logic [WIDTH-1:0]   mag_b,
  input  logic               step,
  output logic [2*WIDTH-1:0] acc,
  output logic               cnt_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] acc_next;

  assign cnt_zero = (cnt == '0);

  // One iteration: multiply adds the multiplicand into the upper half then shifts right;
  // divide shifts the next dividend bit into the remainder and keeps the trial difference if it fits.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    acc_next  = is_div ? div_next : mul_next;
  end

  // Load operands and iteration count, then step until the counter drains.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= {{WIDTH{1'b0}}, mag_a};
      opnd   <= mag_b;
      is_div <= mode_div;
      cnt    <= skip ? '0 : CW'(WIDTH);
    end else if (step && !cnt_zero) begin
      acc <= acc_next;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU with iterative multiply/divide and HI/LO registers.
// Latency: single-cycle ops 1 edge; mult/div WIDTH+2 edges; divide by zero 2 edges.
// Backpressure: busy stalls the issuer; start is ignored while a mult/div is in flight.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [5:0]       operation,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             illegal,
  output logic             busy,
  output logic             done
);
  localparam int SHW = $clog2(WIDTH);

  state_t             state;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               md_div;
  logic               neg_main;
  logic               neg_rem;
  logic               dz_pend;
  logic [WIDTH-1:0]   dz_a;

  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic               alu_ill;

  logic               is_md;
  logic               op_signed;
  logic               op_is_div;
  logic               a_neg;
  logic               b_neg;
  logic               div0;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               mdu_load;
  logic               mdu_step;
  logic               cnt_zero;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   new_hi;
  logic [WIDTH-1:0]   new_lo;

  assign shamt = operandA[SHW-1:0];
  assign sum   = operandA + operandB;
  assign diff  = operandA - operandB;

  // Operand preparation for the iterative unit: signed ops run on magnitudes.
  assign is_md     = is_mdu_op(operation);
  assign op_signed = (operation == FN_MULT) || (operation == FN_DIV);
  assign op_is_div = (operation == FN_DIV) || (operation == FN_DIVU);
  assign a_neg     = op_signed & operandA[WIDTH-1];
  assign b_neg     = op_signed & operandB[WIDTH-1];
  assign mag_a     = a_neg ? -operandA : operandA;
  assign mag_b     = b_neg ? -operandB : operandB;
  assign div0      = op_is_div && (operandB == '0);
  assign mdu_load  = (state == S_IDLE) && start && is_md;
  assign mdu_step  = (state == S_CALC);

  // Sign correction applied to the raw magnitude results in SIGN.
  assign prod = neg_main ? -acc : acc;
  assign quo  = neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .clock    (clock),
    .reset    (reset),
    .load     (mdu_load),
    .mode_div (op_is_div),
    .skip     (div0),
    .mag_a    (mag_a),
    .mag_b    (mag_b),
    .step     (mdu_step),
    .acc      (acc),
    .cnt_zero (cnt_zero)
  );

  // Single-cycle ALU result and flags for the funct code on the inputs.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (operation)
      FN_SLL:  alu_res = operandB << shamt;
      FN_SRL:  alu_res = operandB >> shamt;
      FN_SRA:  alu_res = $signed(operandB) >>> shamt;
      FN_MFHI: alu_res = hi;
      FN_MFLO: alu_res = lo;
      FN_ADD: begin
        alu_res = sum;
        alu_ovf = (operandA[WIDTH-1] == operandB[WIDTH-1]) && (sum[WIDTH-1] != operandA[WIDTH-1]);
      end
      FN_ADDU: alu_res = sum;
      FN_SUB: begin
        alu_res = diff;
        alu_ovf = (operandA[WIDTH-1] != operandB[WIDTH-1]) && (diff[WIDTH-1] != operandA[WIDTH-1]);
      end
      FN_SUBU: alu_res = diff;
      FN_AND:  alu_res = operandA & operandB;
      FN_OR:   alu_res = operandA | operandB;
      FN_XOR:  alu_res = operandA ^ operandB;
      FN_NOR:  alu_res = ~(operandA | operandB);
      FN_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(operandA) < $signed(operandB))};
      FN_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (operandA < operandB)};
      FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  // HI/LO values written at the end of a mult/div; divide by zero bypasses the datapath.
  always_comb begin
    new_hi = prod[2*WIDTH-1:WIDTH];
    new_lo = prod[WIDTH-1:0];
    if (dz_pend) begin
      new_hi = dz_a;
      new_lo = '1;
    end else if (md_div) begin
      new_hi = rem;
      new_lo = quo;
    end
  end

  // Sequencer: issues single-cycle ops directly, runs mult/div through CALC and SIGN.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      hi          <= '0;
      lo          <= '0;
      result      <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      illegal     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      md_div      <= 1'b0;
      neg_main    <= 1'b0;
      neg_rem     <= 1'b0;
      dz_pend     <= 1'b0;
      dz_a        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (is_md) begin
              state    <= S_CALC;
              md_div   <= op_is_div;
              neg_main <= a_neg ^ b_neg;
              neg_rem  <= a_neg;
              dz_pend  <= div0;
              dz_a     <= operandA;
            end else begin
              result      <= alu_res;
              overflow    <= alu_ovf;
              div_by_zero <= 1'b0;
              illegal     <= alu_ill;
              done        <= 1'b1;
            end
          end
        end
        S_CALC: begin
          busy <= 1'b1;
          if (cnt_zero) begin
            state <= S_SIGN;
          end
        end
        S_SIGN: begin
          hi          <= new_hi;
          lo          <= new_lo;
          result      <= new_lo;
          overflow    <= 1'b0;
          div_by_zero <= dz_pend;
          illegal     <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu at WIDTH=32 and WIDTH=8 using a done-driven scoreboard.
// Latency: checks done timing against the accept edge of each operation.
// Backpressure: exercises start-while-busy and mfhi issued on the done edge.
module tb_alu_mdu;
  import alu_mdu_pkg::*;

  localparam logic [5:0] FN_ILL = 6'b111111;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        ovf;
    logic        dz;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic        ill;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;

  logic        s32 = 1'b0;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;
  logic [5:0]  op32 = '0;
  logic [31:0] r32;
  logic        ovf32, dz32, ill32, busy32, done32;

  logic        s8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic [5:0]  op8 = '0;
  logic [7:0]  r8;
  logic        ovf8, dz8, ill8, busy8, done8;

  exp_t q32[$];
  exp_t q8[$];
  exp_t m32;
  exp_t m8;
  vec_t tv[16];

  alu_mdu #(.WIDTH(32)) dut32 (
    .clock(clk), .reset(rst), .start(s32), .operandA(a32), .operandB(b32),
    .operation(op32), .result(r32), .overflow(ovf32), .div_by_zero(dz32),
    .illegal(ill32), .busy(busy32), .done(done32)
  );

  alu_mdu #(.WIDTH(8)) dut8 (
    .clock(clk), .reset(rst), .start(s8), .operandA(a8), .operandB(b8),
    .operation(op8), .result(r8), .overflow(ovf8), .div_by_zero(dz8),
    .illegal(ill8), .busy(busy8), .done(done8)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic vec_t mkv(input string n, input logic [5:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] res,
                               input logic ovf, input logic ill);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b; v.res = res; v.ovf = ovf; v.ill = ill;
    return v;
  endfunction

  // Scoreboard for the 32-bit instance: every done pops one expectation.
  always @(negedge clk) begin
    if (done32) begin
      if (q32.size() == 0) begin
        total++;
        $display("FAIL unexpected_done32 at cycle %0d, result %0h", cyc, r32);
      end else begin
        m32 = q32.pop_front();
        check({m32.name, ".res"}, 64'(r32), 64'(m32.res));
        check({m32.name, ".ovf"}, 64'(ovf32), 64'(m32.ovf));
        check({m32.name, ".dz"}, 64'(dz32), 64'(m32.dz));
        check({m32.name, ".ill"}, 64'(ill32), 64'(m32.ill));
        check({m32.name, ".lat"}, 64'(cyc - m32.acc), 64'(m32.lat));
      end
    end
  end

  // Scoreboard for the 8-bit instance.
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        total++;
        $display("FAIL unexpected_done8 at cycle %0d, result %0h", cyc, r8);
      end else begin
        m8 = q8.pop_front();
        check({m8.name, ".res"}, 64'(r8), 64'(m8.res));
        check({m8.name, ".ovf"}, 64'(ovf8), 64'(m8.ovf));
        check({m8.name, ".dz"}, 64'(dz8), 64'(m8.dz));
        check({m8.name, ".ill"}, 64'(ill8), 64'(m8.ill));
        check({m8.name, ".lat"}, 64'(cyc - m8.acc), 64'(m8.lat));
      end
    end
  end

  task automatic drive32(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string name, input logic [31:0] res, input logic ovf,
                         input logic dz, input logic ill, input int lat);
    exp_t e;
    @(posedge clk); #1;
    s32 = 1'b1; op32 = op; a32 = a; b32 = b;
    e.name = name; e.res = res; e.ovf = ovf; e.dz = dz; e.ill = ill; e.lat = lat; e.acc = cyc + 1;
    q32.push_back(e);
  endtask

  task automatic drive8(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                        input string name, input logic [31:0] res, input logic ovf,
                        input logic dz, input logic ill, input int lat);
    exp_t e;
    @(posedge clk); #1;
    s8 = 1'b1; op8 = op; a8 = a; b8 = b;
    e.name = name; e.res = res; e.ovf = ovf; e.dz = dz; e.ill = ill; e.lat = lat; e.acc = cyc + 1;
    q8.push_back(e);
  endtask

  task automatic idle32;
    @(posedge clk); #1;
    s32 = 1'b0;
  endtask

  task automatic idle8;
    @(posedge clk); #1;
    s8 = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_q32", 64'(q32.size()), 64'd0);
    check("drain_q8", 64'(q8.size()), 64'd0);
  endtask

  task automatic md32(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                      input string name, input logic [31:0] res, input logic dz, input int lat);
    drive32(op, a, b, name, res, 1'b0, dz, 1'b0, lat);
    idle32();
    drain(lat + 20);
  endtask

  task automatic md8(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                     input string name, input logic [31:0] res, input logic ovf,
                     input logic ill, input int lat);
    drive8(op, a, b, name, res, ovf, 1'b0, ill, lat);
    idle8();
    drain(lat + 20);
  endtask

  task automatic rd32(input logic [5:0] op, input string name, input logic [31:0] res);
    drive32(op, 32'h0, 32'h0, name, res, 1'b0, 1'b0, 1'b0, 0);
    idle32();
    drain(10);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int a0;
    int nd;
    int n;
    exp_t e;

    // reset values
    #12;
    check("rst.res32", 64'(r32), 64'd0);
    check("rst.busy32", 64'(busy32), 64'd0);
    check("rst.done32", 64'(done32), 64'd0);
    check("rst.flags32", 64'({ovf32, dz32, ill32}), 64'd0);
    check("rst.res8", 64'(r8), 64'd0);
    check("rst.busy8", 64'(busy8), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    rd32(FN_MFHI, "mfhi_after_rst", 32'h0);
    rd32(FN_MFLO, "mflo_after_rst", 32'h0);

    // single-cycle ops back to back, one result per cycle
    tv[0]  = mkv("add_ovf",  FN_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0);
    tv[1]  = mkv("addu",     FN_ADDU, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0);
    tv[2]  = mkv("sra",      FN_SRA,  32'h00000002, 32'h80000010, 32'hE0000004, 1'b0, 1'b0);
    tv[3]  = mkv("srl",      FN_SRL,  32'h00000002, 32'h80000010, 32'h20000004, 1'b0, 1'b0);
    tv[4]  = mkv("sll",      FN_SLL,  32'h00000003, 32'h00000002, 32'h00000010, 1'b0, 1'b0);
    tv[5]  = mkv("sub_ovf",  FN_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0);
    tv[6]  = mkv("subu",     FN_SUBU, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0);
    tv[7]  = mkv("and",      FN_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0);
    tv[8]  = mkv("or",       FN_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0);
    tv[9]  = mkv("xor",      FN_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0);
    tv[10] = mkv("nor",      FN_NOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1'b0);
    tv[11] = mkv("slt",      FN_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0);
    tv[12] = mkv("sltu",     FN_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0);
    tv[13] = mkv("add_mix",  FN_ADD,  32'h00000005, 32'hFFFFFFFD, 32'h00000002, 1'b0, 1'b0);
    tv[14] = mkv("illegal",  FN_ILL,  32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b1);
    tv[15] = mkv("sra_wrap", FN_SRA,  32'h00000021, 32'h80000000, 32'hC0000000, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      drive32(tv[i].op, tv[i].a, tv[i].b, tv[i].name, tv[i].res, tv[i].ovf, 1'b0, tv[i].ill, 0);
    end
    idle32();
    drain(20);

    // signed multiply
    md32(FN_MULT, 32'hFFFFFFFD, 32'h00000005, "mult_m3x5", 32'hFFFFFFF1, 1'b0, 34);
    rd32(FN_MFHI, "mfhi_m3x5", 32'hFFFFFFFF);
    rd32(FN_MFLO, "mflo_m3x5", 32'hFFFFFFF1);

    // signed divide with a start pulse while busy that must be dropped
    drive32(FN_DIV, 32'hFFFFFFF9, 32'h00000002, "div_m7d2", 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0, 34);
    idle32();
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("div_busy_mid", 64'(busy32), 64'd1);
    @(posedge clk); #1;
    s32 = 1'b1; op32 = FN_ADD; a32 = 32'h1; b32 = 32'h1;
    @(posedge clk); #1;
    s32 = 1'b0;
    drain(60);
    check("div_busy_after", 64'(busy32), 64'd0);
    rd32(FN_MFHI, "mfhi_m7d2", 32'hFFFFFFFF);

    // divide by zero, unsigned and signed
    md32(FN_DIVU, 32'h00000007, 32'h00000000, "divu_by0", 32'hFFFFFFFF, 1'b1, 2);
    rd32(FN_MFHI, "mfhi_divu_by0", 32'h00000007);
    md32(FN_DIV, 32'hFFFFFFF9, 32'h00000000, "div_by0", 32'hFFFFFFFF, 1'b1, 2);
    rd32(FN_MFHI, "mfhi_div_by0", 32'hFFFFFFF9);

    // most negative / -1
    md32(FN_DIV, 32'h80000000, 32'hFFFFFFFF, "div_minneg", 32'h80000000, 1'b0, 34);
    rd32(FN_MFHI, "mfhi_minneg", 32'h00000000);

    // full-scale unsigned multiply
    md32(FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max", 32'h00000001, 1'b0, 34);
    rd32(FN_MFHI, "mfhi_multu_max", 32'hFFFFFFFE);

    // mfhi held on start across the done edge is taken the next cycle and sees the new HI
    drive32(FN_MULT, 32'h00000006, 32'h00000007, "mult_6x7", 32'h0000002A, 1'b0, 1'b0, 1'b0, 34);
    a0 = cyc + 1;
    @(posedge clk); #1;
    op32 = FN_MFHI; a32 = '0; b32 = '0;
    e.name = "mfhi_done_edge"; e.res = 32'h0; e.ovf = 1'b0; e.dz = 1'b0; e.ill = 1'b0;
    e.lat = 0; e.acc = a0 + 35;
    q32.push_back(e);
    nd = 0;
    n = 0;
    while (nd < 2 && n < 60) begin
      @(negedge clk);
      if (done32) nd++;
      n++;
    end
    s32 = 1'b0;
    check("mfhi_done_edge.seen", 64'(nd), 64'd2);
    drain(10);

    // 8-bit instance
    md8(FN_MULTU, 8'hFF, 8'hFF, "w8_multu", 32'h01, 1'b0, 1'b0, 10);
    drive8(FN_MFHI, 8'h0, 8'h0, "w8_mfhi", 32'hFE, 1'b0, 1'b0, 1'b0, 0);
    drive8(FN_ILL, 8'h5A, 8'hA5, "w8_illegal", 32'h00, 1'b0, 1'b0, 1'b1, 0);
    drive8(FN_ADD, 8'h7F, 8'h01, "w8_add_ovf", 32'h80, 1'b1, 1'b0, 1'b0, 0);
    idle8();
    drain(10);
    md8(FN_MULT, 8'h80, 8'hFF, "w8_mult_minneg", 32'h80, 1'b0, 1'b0, 10);
    md8(FN_MFHI, 8'h0, 8'h0, "w8_mfhi_mult", 32'h00, 1'b0, 1'b0, 0);
    md8(FN_DIV, 8'h80, 8'hFF, "w8_div_minneg", 32'h80, 1'b0, 1'b0, 10);

    // reset in the middle of a multiply: everything clears, no done ever arrives
    md32(FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_pre_rst", 32'h00000001, 1'b0, 34);
    @(posedge clk); #1;
    s32 = 1'b1; op32 = FN_MULT; a32 = 32'h3; b32 = 32'h5;
    a0 = cyc + 1;
    @(posedge clk); #1;
    s32 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_mid.busy_before", 64'(busy32), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_mid.res", 64'(r32), 64'd0);
    check("rst_mid.busy", 64'(busy32), 64'd0);
    check("rst_mid.done", 64'(done32), 64'd0);
    check("rst_mid.flags", 64'({ovf32, dz32, ill32}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    rd32(FN_MFHI, "mfhi_rst_mid", 32'h0);
    rd32(FN_MFLO, "mflo_rst_mid", 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
